// File: rtl/debouncer_pkg.sv
// debouncer_pkg
// Shared definitions for the multi-channel debouncer.
//   state_t     : per-channel FSM state. Bit 1 of the encoding is the
//                 debounced level, so the output is a plain bit decode.
//   SYNC_STAGES : number of synchroniser flops in front of each FSM.
//                 It is 2 when DEBOUNCER_MULTI_SYNC_EN is defined and 0
//                 otherwise.
package debouncer_pkg;

    typedef enum logic [1:0] {
        S_LOW       = 2'b00,
        S_WAIT_HIGH = 2'b01,
        S_HIGH      = 2'b11,
        S_WAIT_LOW  = 2'b10
    } state_t;

`ifdef DEBOUNCER_MULTI_SYNC_EN
    localparam int SYNC_STAGES = 2;
`else
    localparam int SYNC_STAGES = 0;
`endif

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
// Single-bit debouncer made of an optional synchroniser, a four-state FSM,
// a stability counter and the tick registers.
// Optional feature: DEBOUNCER_MULTI_SYNC_EN inserts a 2-flop synchroniser
// in front of the FSM. Without it, noisy is assumed synchronous to clk.
// Ports:
//   clk        in  system clock, rising edge
//   reset      in  synchronous, active-high reset
//   noisy      in  raw input bit
//   debounced  out filtered level
//   rise_tick  out one-cycle pulse when debounced goes 0->1
//   fall_tick  out one-cycle pulse when debounced goes 1->0
module debounce_channel
    import debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = 5_000_000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic noisy,
    output logic debounced,
    output logic rise_tick,
    output logic fall_tick
);

    // The WAIT state is left while count equals this value. The entry
    // cycle and the final cycle each account for one sample, so the total
    // qualification time is STABLE_CYCLES.
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(STABLE_CYCLES - 2);

    logic             sample;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

`ifdef DEBOUNCER_MULTI_SYNC_EN
    logic [SYNC_STAGES-1:0] sync_ff;

    // Two-flop synchroniser that brings the asynchronous input into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], noisy};
        end
    end

    assign sample = sync_ff[SYNC_STAGES-1];
`else
    assign sample = noisy;
`endif

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_LOW;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next-state logic. Any opposing sample during a WAIT state returns to
    // the stable state, and the count restarts on the next attempt.
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            S_LOW: begin
                if (sample) begin
                    state_next = S_WAIT_HIGH;
                    count_next = '0;
                end
            end
            S_WAIT_HIGH: begin
                if (!sample) begin
                    state_next = S_LOW;
                    count_next = '0;
                end else if (count == LAST_COUNT) begin
                    state_next = S_HIGH;
                end else begin
                    count_next = count + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!sample) begin
                    state_next = S_WAIT_LOW;
                    count_next = '0;
                end
            end
            S_WAIT_LOW: begin
                if (sample) begin
                    state_next = S_HIGH;
                    count_next = '0;
                end else if (count == LAST_COUNT) begin
                    state_next = S_LOW;
                end else begin
                    count_next = count + CNT_W'(1);
                end
            end
            default: begin
                state_next = S_LOW;
                count_next = '0;
            end
        endcase
    end

    // Registered level decode and edge ticks. Each tick is formed from the
    // new level against the previous level, so it coincides with the
    // change on debounced. Both ticks cannot be high at the same time.
    always_ff @(posedge clk) begin
        if (reset) begin
            debounced <= 1'b0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            debounced <= state[1];
            rise_tick <= state[1] & ~debounced;
            fall_tick <= ~state[1] & debounced;
        end
    end

endmodule

// File: rtl/debouncer_multi.sv
// debouncer_multi
// N-channel push-button/switch debouncer. Each channel is independent. A
// level change is accepted only after the input has held its new value for
// STABLE_CYCLES consecutive samples.
// Optional feature: DEBOUNCER_MULTI_SYNC_EN adds a 2-flop synchroniser per
// channel, which adds 2 cycles of latency.
// Ports:
//   clk        in  system clock, rising edge
//   reset      in  synchronous, active-high reset
//   noisy      in  [CHANNELS] raw inputs
//   debounced  out [CHANNELS] filtered levels
//   rise_tick  out [CHANNELS] one-cycle pulse on each 0->1 of debounced
//   fall_tick  out [CHANNELS] one-cycle pulse on each 1->0 of debounced
module debouncer_multi
    import debouncer_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 5_000_000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] noisy,
    output logic [CHANNELS-1:0] debounced,
    output logic [CHANNELS-1:0] rise_tick,
    output logic [CHANNELS-1:0] fall_tick
);

    // One independent debouncer per input bit.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_channel (
            .clk       (clk),
            .reset     (reset),
            .noisy     (noisy[i]),
            .debounced (debounced[i]),
            .rise_tick (rise_tick[i]),
            .fall_tick (fall_tick[i])
        );
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// tb_debouncer_multi
// Directed self-checking bench for debouncer_multi with 4 channels,
// STABLE_CYCLES = 8 and a 10 ns clock. Expected latency follows the build:
// 8 + 2 cycles with DEBOUNCER_MULTI_SYNC_EN defined, and 8 cycles without it.
// Inputs are driven on the falling edge, and outputs are sampled on the
// falling edge before any new drive.
module tb_debouncer_multi;

    localparam int CHANNELS = 4;
    localparam int STABLE   = 8;
`ifdef DEBOUNCER_MULTI_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT = STABLE + SYNC;

    logic                clk = 1'b0;
    logic                reset;
    logic [CHANNELS-1:0] noisy;
    logic [CHANNELS-1:0] debounced;
    logic [CHANNELS-1:0] rise_tick;
    logic [CHANNELS-1:0] fall_tick;

    int checks_total  = 0;
    int checks_passed = 0;

    debouncer_multi #(
        .CHANNELS      (CHANNELS),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .noisy     (noisy),
        .debounced (debounced),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // 10 ns free-running clock.
    always #5 clk = ~clk;

    // Hard time limit. An expired limit is reported as a failure.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reset with all inputs low; outputs must stay quiet for 20 cycles.
    task automatic test_reset();
        logic [11:0] obs;
        reset = 1'b1;
        noisy = '0;
        repeat (3) @(negedge clk);
        obs = {debounced, rise_tick, fall_tick};
        checks_total++;
        if (obs !== 12'h000)
            $display("[TB] FAIL reset_held: got %b expected %b", obs, 12'h000);
        else
            checks_passed++;
        reset = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            obs = {debounced, rise_tick, fall_tick};
            checks_total++;
            if (obs !== 12'h000)
                $display("[TB] FAIL reset_quiet[%0d]: got %b expected %b", j, obs, 12'h000);
            else
                checks_passed++;
        end
    endtask

    // Clean rise on channel 0 appears exactly LAT cycles after the sampling edge.
    task automatic test_single_rise();
        logic [11:0] obs;
        logic [11:0] exp;
        noisy[0] = 1'b1;
        for (int j = 1; j <= LAT + 2; j++) begin
            @(negedge clk);
            exp    = '0;
            exp[8] = (j >= LAT + 1);
            exp[4] = (j == LAT + 1);
            obs = {debounced, rise_tick, fall_tick};
            checks_total++;
            if (obs !== exp)
                $display("[TB] FAIL single_rise[%0d]: got %b expected %b", j, obs, exp);
            else
                checks_passed++;
        end
    endtask

    // Channel 1 toggles every 3 cycles for 40 cycles, then is held high.
    task automatic test_bounce();
        logic [11:0] obs;
        logic [11:0] exp;
        for (int c = 0; c < 40; c++) begin
            if (c % 3 == 0) noisy[1] = ~noisy[1];
            @(negedge clk);
            obs = {debounced, rise_tick, fall_tick};
            checks_total++;
            if (obs !== 12'b0001_0000_0000)
                $display("[TB] FAIL bounce_hold[%0d]: got %b expected %b", c, obs, 12'b0001_0000_0000);
            else
                checks_passed++;
        end
        noisy[1] = 1'b1;
        for (int j = 1; j <= LAT + 2; j++) begin
            @(negedge clk);
            exp    = 12'b0001_0000_0000;
            exp[9] = (j >= LAT + 1);
            exp[5] = (j == LAT + 1);
            obs = {debounced, rise_tick, fall_tick};
            checks_total++;
            if (obs !== exp)
                $display("[TB] FAIL bounce_rise[%0d]: got %b expected %b", j, obs, exp);
            else
                checks_passed++;
        end
    endtask

    // Channel 2: a 7-cycle low pulse is rejected, and an 8-cycle low pulse is accepted.
    task automatic test_glitch();
        logic [11:0] obs;
        logic [11:0] exp;
        noisy[2] = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        obs = {debounced, rise_tick, fall_tick};
        checks_total++;
        if (obs !== 12'b0111_0000_0000)
            $display("[TB] FAIL glitch_setup: got %b expected %b", obs, 12'b0111_0000_0000);
        else
            checks_passed++;

        noisy[2] = 1'b0;
        for (int j = 1; j <= LAT + 4; j++) begin
            @(negedge clk);
            obs = {debounced, rise_tick, fall_tick};
            checks_total++;
            if (obs !== 12'b0111_0000_0000)
                $display("[TB] FAIL glitch7[%0d]: got %b expected %b", j, obs, 12'b0111_0000_0000);
            else
                checks_passed++;
            if (j == 7) noisy[2] = 1'b1;
        end

        noisy[2] = 1'b0;
        for (int j = 1; j <= LAT + 4; j++) begin
            @(negedge clk);
            exp    = 12'b0111_0000_0000;
            exp[10] = (j < LAT + 1);
            exp[2]  = (j == LAT + 1);
            obs = {debounced, rise_tick, fall_tick};
            checks_total++;
            if (obs !== exp)
                $display("[TB] FAIL glitch8[%0d]: got %b expected %b", j, obs, exp);
            else
                checks_passed++;
            if (j == 8) noisy[2] = 1'b1;
        end
    endtask

    // All channels rise together after reset, then hold steady with no ticks.
    task automatic test_simultaneous();
        logic [11:0] obs;
        logic [11:0] exp;
        reset = 1'b1;
        noisy = '0;
        repeat (2) @(negedge clk);
        obs = {debounced, rise_tick, fall_tick};
        checks_total++;
        if (obs !== 12'h000)
            $display("[TB] FAIL sim_reset: got %b expected %b", obs, 12'h000);
        else
            checks_passed++;
        reset = 1'b0;
        noisy = 4'b1111;
        for (int j = 1; j <= LAT + 10; j++) begin
            @(negedge clk);
            exp = '0;
            if (j >= LAT + 1) exp[11:8] = 4'b1111;
            if (j == LAT + 1) exp[7:4]  = 4'b1111;
            obs = {debounced, rise_tick, fall_tick};
            checks_total++;
            if (obs !== exp)
                $display("[TB] FAIL simultaneous[%0d]: got %b expected %b", j, obs, exp);
            else
                checks_passed++;
        end
    endtask

    // Reset at count 5 of a channel 3 qualification aborts it; a full new one follows.
    task automatic test_reset_mid_count();
        logic [11:0] obs;
        logic [11:0] exp;
        reset = 1'b1;
        noisy = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        noisy[3] = 1'b1;
        for (int j = 1; j <= SYNC + 6; j++) begin
            @(negedge clk);
            obs = {debounced, rise_tick, fall_tick};
            checks_total++;
            if (obs !== 12'h000)
                $display("[TB] FAIL midreset_count[%0d]: got %b expected %b", j, obs, 12'h000);
            else
                checks_passed++;
        end
        reset = 1'b1;
        @(negedge clk);
        obs = {debounced, rise_tick, fall_tick};
        checks_total++;
        if (obs !== 12'h000)
            $display("[TB] FAIL midreset_pulse: got %b expected %b", obs, 12'h000);
        else
            checks_passed++;
        reset = 1'b0;
        for (int j = 1; j <= LAT + 2; j++) begin
            @(negedge clk);
            exp     = '0;
            exp[11] = (j >= LAT + 1);
            exp[7]  = (j == LAT + 1);
            obs = {debounced, rise_tick, fall_tick};
            checks_total++;
            if (obs !== exp)
                $display("[TB] FAIL midreset_rise[%0d]: got %b expected %b", j, obs, exp);
            else
                checks_passed++;
        end
    endtask

    // Scenario sequence.
    initial begin
        reset = 1'b1;
        noisy = '0;
        test_reset();
        test_single_rise();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid_count();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/debouncer_multi.md
# debouncer_multi

Parametrised N-channel switch/button debouncer, successor to the single-channel delayed debouncer. Each channel samples a raw asynchronous input. The debounced level changes only after the input has held its new value for a programmable number of consecutive clock cycles. Each level change also produces a one-cycle rise or fall tick. It sits between board-level push-buttons/switches and the control logic, so one instance serves a whole button bank.

## Interface
- `CHANNELS`, default 4: number of independent input channels (1..32).
- `STABLE_CYCLES`, default 5_000_000: consecutive stable samples required before a level change (50 ms at 100 MHz); ≥ 2.
- `CNT_W`, default `$clog2(STABLE_CYCLES)`: counter width; derived, not overridden by users.
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: synchronous, active-high reset.
- `noisy` in CHANNELS: raw, asynchronous inputs.
- `debounced` out CHANNELS: filtered levels.
- `rise_tick` out CHANNELS: one-cycle pulse when `debounced[i]` goes 0→1.
- `fall_tick` out CHANNELS: one-cycle pulse when `debounced[i]` goes 1→0.

## Operation
- Channels are fully independent. They share only `clk` and `reset`.
- Per-channel FSM has four states:
  - S_LOW (`debounced`=0).
  - S_WAIT_HIGH (`debounced`=0, counting).
  - S_HIGH (`debounced`=1).
  - S_WAIT_LOW (`debounced`=1, counting).
- S_LOW: sample=1 → S_WAIT_HIGH, count cleared to 0.
- S_WAIT_HIGH:
  - sample=0 → S_LOW, count cleared.
  - sample=1 and count = STABLE_CYCLES-2 → S_HIGH.
  - Otherwise count+1.
- S_HIGH and S_WAIT_LOW mirror S_LOW and S_WAIT_HIGH with the polarity inverted.
- Any single opposing sample during a WAIT state aborts the change. There is no partial credit: count restarts from 0 on the next transition attempt.
- The counter is CNT_W bits and saturates by construction, because the FSM leaves the WAIT state before overflow.
- `debounced` is a registered decode of the state, i.e. bit 1 of the encoding.
- Ticks are registered and asserted for exactly one cycle, in the same cycle `debounced` changes.
- `rise_tick` and `fall_tick` of one channel are never high together.

## Timing
- Reset: all states → S_LOW, counters 0, `debounced`=0, `rise_tick`=0, `fall_tick`=0, synchroniser flops 0.
- Latency from a clean edge on `noisy[i]` (sampled at clock edge k) to the `debounced[i]` change: STABLE_CYCLES + SYNC_STAGES clocks.
  - SYNC_STAGES = 2 with the synchroniser compiled in, 0 without.
- A pulse or glitch shorter than STABLE_CYCLES samples never changes `debounced`.
- Reset asserted mid-count: the channel returns to S_LOW next edge and no tick is emitted. If `noisy` is still 1 after reset releases, a full new STABLE_CYCLES qualification is required.
- Input held constant: outputs are static, no ticks.

## Configuration
- Macro `DEBOUNCER_MULTI_SYNC_EN`.
- Defined: each `noisy[i]` passes through a 2-flop synchroniser (reset to 0) before the FSM; latency includes +2 cycles.
- Undefined: `noisy` feeds the FSM directly. This is for inputs already synchronous to `clk` and for fast simulation; latency is exactly STABLE_CYCLES.

## Structure
- Shared package `debouncer_pkg` holds:
  - The state encodings S_LOW=2'b00, S_WAIT_HIGH=2'b01, S_HIGH=2'b11, S_WAIT_LOW=2'b10 (bit 1 = debounced level).
  - `SYNC_STAGES` localparam.
- One sub-module, `debounce_channel`: synchroniser, FSM, counter and tick logic for a single bit.
  - Parameters: STABLE_CYCLES and CNT_W.
- `debouncer_multi` instantiates `debounce_channel` CHANNELS times in a generate loop.

## Test plan
Bench uses CHANNELS=4, STABLE_CYCLES=8, 10 ns clock, sync enabled.
- Reset release with `noisy`=4'b0000 → all outputs 0 for 20 cycles, no ticks.
- `noisy[0]` 0→1 held → `debounced[0]`=1 and `rise_tick[0]` high exactly 10 cycles after the sampling edge, for 1 cycle; other channels unaffected.
- `noisy[1]` toggled every 3 cycles for 40 cycles, then held at 1 → no change during the bounce; `debounced[1]` rises 10 cycles after the final edge.
- `debounced[2]`=1, then a 7-cycle low pulse on `noisy[2]` → `debounced[2]` stays 1, no `fall_tick`. Repeating with an 8-cycle low pulse → `fall_tick[2]` fires and `debounced[2]`=0.
- Simultaneous 0→1 on all four channels → all `rise_tick` bits high in the same cycle, `debounced`=4'b1111.
- `reset` asserted for 1 cycle at count 5 of a rising qualification on channel 3 → `debounced[3]` stays 0, no tick. With `noisy[3]` still 1, the rise appears 10 cycles after reset deasserts.
